mod_updown_counter: RTL and testbench



---
 rtl/counter_pkg.sv | 14 +
 rtl/mod_updown_counter_if.sv | 27 ++
 rtl/mod_updown_counter_tick_prescaler.sv | 50 +++++
 rtl/mod_updown_counter.sv | 88 ++++++++
 tb/tb_mod_updown_counter.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down counter and its prescaler.
package counter_pkg;

    localparam logic CNT_UP   = 1'b1;
    localparam logic CNT_DOWN = 1'b0;

    // Prescaler counter width: enough bits to hold PRESCALE-1, never less than one.
    function automatic int prescale_width(input int prescale);
        int w;
        w = $clog2(prescale);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mod_updown_counter_if.sv
// Control/status bundle of the up/down counter.
// Handshake: there is no valid/ready pair; every control input is sampled on
// each rising clk edge, and q/tc/ovf are registered outputs that change only
// on that edge.
interface mod_updown_counter_if #(
    parameter int N = 8
);
    logic         start;
    logic         en;
    logic         up;
    logic         load;
    logic [N-1:0] load_val;
    logic [N-1:0] mod_max;
    logic [N-1:0] q;
    logic         tc;
    logic         ovf;

    modport master (
        output start, en, up, load, load_val, mod_max,
        input  q, tc, ovf
    );

    modport slave (
        input  start, en, up, load, load_val, mod_max,
        output q, tc, ovf
    );
endinterface

// File: rtl/mod_updown_counter_tick_prescaler.sv
// Enable prescaler: emits one tick every PRESCALE enabled cycles.
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    generate
        if (PRESCALE == 1) begin : g_pass
            // Every enabled cycle is a step; no state needed.
            logic unused_ok;
            assign unused_ok = clk ^ rst ^ clr;
            assign tick      = en;
        end else begin : g_div
            localparam int W = prescale_width(PRESCALE);
            localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

            logic [W-1:0] cnt_q;
            logic [W-1:0] cnt_d;

            // Count enabled cycles 0..PRESCALE-1; clr restarts the phase.
            always_comb begin
                cnt_d = cnt_q;
                if (clr) begin
                    cnt_d = '0;
                end else if (en) begin
                    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
                end
            end

            // Phase register.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign tick = en && (cnt_q == LAST);
        end
    endgenerate

endmodule

// File: rtl/mod_updown_counter.sv
// N-bit modulo up/down counter with load, prescaled enable, wrap/saturate
// mode, terminal-count pulse and sticky overflow.
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int N        = 8,
    parameter int PRESCALE = 1,
    parameter int SATURATE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    mod_updown_counter_if.slave  bus
);

    localparam bit SAT = (SATURATE != 0);

    logic [N-1:0] q_q, q_d;
    logic         tc_q, tc_d;
    logic         ovf_q, ovf_d;
    logic         tick;
    logic         pre_clr;

    // Start-low and load both restart the prescaler phase.
    assign pre_clr = !bus.start || bus.load;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (pre_clr),
        .en   (bus.en),
        .tick (tick)
    );

    // Next state: start-low clear > load > step > hold; tc defaults low.
    always_comb begin
        q_d   = q_q;
        tc_d  = 1'b0;
        ovf_d = ovf_q;
        if (!bus.start) begin
            q_d   = '0;
            ovf_d = 1'b0;
        end else if (bus.load) begin
            q_d = (bus.load_val > bus.mod_max) ? bus.mod_max : bus.load_val;
        end else if (tick) begin
            if (bus.up == CNT_UP) begin
                // >= so a lowered mod_max never lets the count run past it.
                if (q_q >= bus.mod_max) begin
                    tc_d  = 1'b1;
                    ovf_d = 1'b1;
                    q_d   = SAT ? bus.mod_max : '0;
                end else begin
                    q_d = q_q + 1'b1;
                end
            end else begin
                if (q_q > bus.mod_max) begin
                    // Pull back into range after mod_max was lowered; not terminal.
                    q_d = bus.mod_max;
                end else if (q_q == '0) begin
                    tc_d  = 1'b1;
                    ovf_d = 1'b1;
                    q_d   = SAT ? '0 : bus.mod_max;
                end else begin
                    q_d = q_q - 1'b1;
                end
            end
        end
    end

    // Output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q   <= '0;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.q   = q_q;
    assign bus.tc  = tc_q;
    assign bus.ovf = ovf_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: three instances (wrap, saturate, prescale=3)
// share one stimulus; a reference model fills an expected queue each cycle.
module tb_mod_updown_counter;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         en;
    logic         up;
    logic         load;
    logic [N-1:0] load_val;
    logic [N-1:0] mod_max;

    int n_checks = 0;
    int n_errors = 0;

    logic [29:0] exp_q[$];

    // Reference model state, index 0=wrap, 1=saturate, 2=prescale 3.
    int           m_pre [3];
    logic [N-1:0] m_q   [3];
    logic         m_tc  [3];
    logic         m_ovf [3];
    int           cfg_p [3] = '{1, 1, 3};
    bit           cfg_s [3] = '{0, 1, 0};

    always #5 clk = ~clk;

    mod_updown_counter_if #(.N(N)) if_w ();
    mod_updown_counter_if #(.N(N)) if_s ();
    mod_updown_counter_if #(.N(N)) if_p ();

    assign if_w.start = start;  assign if_s.start = start;  assign if_p.start = start;
    assign if_w.en    = en;     assign if_s.en    = en;     assign if_p.en    = en;
    assign if_w.up    = up;     assign if_s.up    = up;     assign if_p.up    = up;
    assign if_w.load  = load;   assign if_s.load  = load;   assign if_p.load  = load;
    assign if_w.load_val = load_val; assign if_s.load_val = load_val; assign if_p.load_val = load_val;
    assign if_w.mod_max  = mod_max;  assign if_s.mod_max  = mod_max;  assign if_p.mod_max  = mod_max;

    mod_updown_counter #(.N(N), .PRESCALE(1), .SATURATE(0)) dut_w (.clk(clk), .rst(rst), .bus(if_w));
    mod_updown_counter #(.N(N), .PRESCALE(1), .SATURATE(1)) dut_s (.clk(clk), .rst(rst), .bus(if_s));
    mod_updown_counter #(.N(N), .PRESCALE(3), .SATURATE(0)) dut_p (.clk(clk), .rst(rst), .bus(if_p));

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Advance the model by one rising edge using the currently driven inputs.
    task automatic model_step();
        for (int c = 0; c < 3; c++) begin
            m_tc[c] = 1'b0;
            if (rst || !start) begin
                m_q[c] = '0; m_pre[c] = 0; m_ovf[c] = 1'b0;
            end else if (load) begin
                m_q[c]   = (load_val > mod_max) ? mod_max : load_val;
                m_pre[c] = 0;
            end else if (en) begin
                if (m_pre[c] == cfg_p[c] - 1) begin
                    m_pre[c] = 0;
                    if (up) begin
                        if (m_q[c] < mod_max) m_q[c] = m_q[c] + 8'd1;
                        else begin
                            m_tc[c] = 1'b1; m_ovf[c] = 1'b1;
                            m_q[c] = cfg_s[c] ? mod_max : 8'd0;
                        end
                    end else begin
                        if (m_q[c] > mod_max) m_q[c] = mod_max;
                        else if (m_q[c] != 0) m_q[c] = m_q[c] - 8'd1;
                        else begin
                            m_tc[c] = 1'b1; m_ovf[c] = 1'b1;
                            m_q[c] = cfg_s[c] ? 8'd0 : mod_max;
                        end
                    end
                end else begin
                    m_pre[c] = m_pre[c] + 1;
                end
            end
        end
    endtask

    // One clock: predict, push, let the edge happen, then pop and compare.
    task automatic cyc();
        logic [29:0] e;
        model_step();
        exp_q.push_back({m_q[0], m_tc[0], m_ovf[0],
                         m_q[1], m_tc[1], m_ovf[1],
                         m_q[2], m_tc[2], m_ovf[2]});
        @(posedge clk);
        #1;
        check_val("sb_depth", exp_q.size(), 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_val("w_q",   if_w.q,   e[29:22]);
            check_val("w_tc",  if_w.tc,  e[21]);
            check_val("w_ovf", if_w.ovf, e[20]);
            check_val("s_q",   if_s.q,   e[19:12]);
            check_val("s_tc",  if_s.tc,  e[11]);
            check_val("s_ovf", if_s.ovf, e[10]);
            check_val("p_q",   if_p.q,   e[9:2]);
            check_val("p_tc",  if_p.tc,  e[1]);
            check_val("p_ovf", if_p.ovf, e[0]);
        end
    endtask

    initial begin
        logic en_pat [7] = '{1, 0, 1, 1, 1, 1, 1};
        for (int c = 0; c < 3; c++) begin
            m_q[c] = '0; m_pre[c] = 0; m_tc[c] = 1'b0; m_ovf[c] = 1'b0;
        end
        rst = 1'b1; start = 1'b0; en = 1'b0; up = 1'b1;
        load = 1'b0; load_val = '0; mod_max = 8'd255;

        // Reset
        repeat (2) cyc();
        check_val("rst_q", if_w.q, 0);
        check_val("rst_ovf", if_s.ovf, 0);

        // Full-range count up with wrap at 255
        rst = 1'b0; start = 1'b1; en = 1'b1;
        cyc();
        check_val("first_step", if_w.q, 1);
        repeat (255) cyc();
        check_val("wrap255_q", if_w.q, 0);
        check_val("wrap255_tc", if_w.tc, 1);
        check_val("wrap255_ovf", if_w.ovf, 1);
        check_val("sat255_q", if_s.q, 255);
        check_val("pre256_q", if_p.q, 85);
        start = 1'b0;
        cyc();
        check_val("startlow_q", if_w.q, 0);
        check_val("startlow_ovf", if_w.ovf, 0);

        // Modulus 9, up then down
        start = 1'b1; mod_max = 8'd9;
        repeat (10) cyc();
        check_val("mod9_wrap_q", if_w.q, 0);
        check_val("mod9_wrap_tc", if_w.tc, 1);
        repeat (2) cyc();
        start = 1'b0; cyc();
        start = 1'b1; up = 1'b0;
        cyc();
        check_val("mod9_down_q", if_w.q, 9);
        check_val("mod9_down_tc", if_w.tc, 1);
        check_val("sat_down_q", if_s.q, 0);
        repeat (3) cyc();
        check_val("mod9_down3_q", if_w.q, 6);

        // Saturate at 5 up, then hold at 0 down
        start = 1'b0; cyc();
        start = 1'b1; up = 1'b1; mod_max = 8'd5;
        repeat (8) cyc();
        check_val("sat_up_q", if_s.q, 5);
        check_val("sat_up_tc", if_s.tc, 1);
        check_val("sat_up_ovf", if_s.ovf, 1);
        up = 1'b0;
        repeat (8) cyc();
        check_val("sat_dn_q", if_s.q, 0);
        check_val("sat_dn_tc", if_s.tc, 1);

        // Prescaler with a gap in en
        start = 1'b0; cyc();
        start = 1'b1; up = 1'b1; mod_max = 8'd255;
        for (int i = 0; i < 7; i++) begin
            en = en_pat[i];
            cyc();
            if (i == 2) check_val("pre_hold_q", if_p.q, 0);
            if (i == 3) check_val("pre_step1_q", if_p.q, 1);
        end
        check_val("pre_step2_q", if_p.q, 2);

        // Load clamp, load beats step, reset beats terminal event
        en = 1'b0; mod_max = 8'd100; load = 1'b1; load_val = 8'd200;
        cyc();
        check_val("load_clamp_q", if_w.q, 100);
        en = 1'b1; load_val = 8'd7;
        cyc();
        check_val("load_step_q", if_w.q, 7);
        check_val("load_step_tc", if_w.tc, 0);
        load_val = 8'd100;
        cyc();
        load = 1'b0; rst = 1'b1;
        cyc();
        check_val("rst_term_q", if_w.q, 0);
        check_val("rst_term_tc", if_w.tc, 0);
        rst = 1'b0;

        // mod_max lowered below the count
        start = 1'b0; cyc();
        start = 1'b1; up = 1'b1; mod_max = 8'd255;
        repeat (50) cyc();
        check_val("dyn_50_q", if_w.q, 50);
        mod_max = 8'd20;
        cyc();
        check_val("dyn_up_q", if_w.q, 0);
        check_val("dyn_up_tc", if_w.tc, 1);
        check_val("dyn_up_sat_q", if_s.q, 20);
        start = 1'b0; cyc();
        start = 1'b1; mod_max = 8'd255;
        repeat (50) cyc();
        mod_max = 8'd20; up = 1'b0;
        cyc();
        check_val("dyn_dn_q", if_w.q, 20);
        check_val("dyn_dn_tc", if_w.tc, 0);

        // Random mix
        for (int i = 0; i < 300; i++) begin
            rst      = ($urandom_range(0, 49) == 0);
            start    = ($urandom_range(0, 19) != 0);
            en       = ($urandom_range(0, 3) != 0);
            up       = $urandom_range(0, 1);
            load     = ($urandom_range(0, 9) == 0);
            load_val = 8'($urandom_range(0, 20));
            if ($urandom_range(0, 15) == 0) mod_max = 8'($urandom_range(0, 15));
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
